inv_sub_bytes: RTL and testbench
================================

Name: inv_sub_bytes

Overview:
- AES InvSubBytes stage for the decryption datapath.
- Applies the FIPS-197 inverse S-box independently to each of the 16 bytes of a 128-bit state.
- Output is registered, with one clock of latency and a simple valid qualifier.
- Sits between InvShiftRows and AddRoundKey in the inverse cipher round.

Parameters:
- None. Width is fixed at 128 bits (16 bytes).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  data_in carries a state to transform this cycle.
- data_in  input  128  input state; byte k = data_in[127-8k -: 8], k=0..15.
- out_valid  output  1  data_out holds a fresh result this cycle.
- data_out  output  128  transformed state, same byte ordering as data_in.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: when rst is sampled high on a rising edge, data_out <= 128'h0 and out_valid <= 0.
  - Reset has priority over in_valid.
  - A transfer presented in the same cycle as reset is discarded.
- Transform: for every byte k, data_out byte k = InvSbox(data_in byte k).
  - InvSbox is the standard FIPS-197 inverse S-box, implemented as a 256-entry combinational lookup.
  - The lookup is replicated 16 times, one per byte.
  - No dependence between bytes; no arithmetic carries.
- Latency: exactly 1 cycle.
  - Given in_valid=1 with value X at edge n, data_out=InvSbox(X) and out_valid=1 are visible after edge n.
  - They remain valid until edge n+1.
- Throughput: one state per cycle. Back-to-back valid inputs produce back-to-back valid outputs, in order.
- Idle: when in_valid=0 (and rst=0), out_valid <= 0 and data_out holds its previous value. It is not cleared.
- No backpressure: the consumer must accept data when out_valid=1.
- out_valid is a registered copy of in_valid, gated by reset.
- Boundary values:
  - InvSbox(8'h63)=8'h00.
  - InvSbox(8'h00)=8'h52.
  - InvSbox(8'hFF)=8'h7D.
  - InvSbox(8'h7C)=8'h01.
- Property: the table is the exact inverse of the forward S-box. Sbox(InvSbox(b))=b for all 256 values of b.
- No X propagation: data_out and out_valid are defined from the first reset onward.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and data_in=all ones -> data_out=128'h0 and out_valid=0 during and immediately after reset.
- FIPS-197 vector: data_in=128'hd42711aee0bf98f1b8b45de51e415230 with in_valid=1 for one cycle.
  - Next cycle: data_out=128'h193de3bea0f4e22b9ac68d2ae9f84808 and out_valid=1.
  - Following cycle: out_valid=0 with data_out unchanged.
- Constant states, driven back-to-back: data_in=128'h0 then 128'h6363…63 (all bytes 63) -> data_out=128'h5252…52 then 128'h0 on consecutive cycles, with out_valid=1 on both.
- Byte-position check: data_in=128'h00…00FF (only byte 15 = FF) -> data_out=128'h5252…527D, which confirms the byte lanes are independent and in the correct order.
- Exhaustive table check: sweep b=0..255, driving every byte lane with b.
  - Every output byte must equal the FIPS-197 InvSbox(b).
  - Forward S-box applied to each output byte must return b.
- Reset mid-stream: stream 3 valid states and assert rst in the cycle the 2nd is presented -> the 2nd result is never presented and out_valid=0.
  - The 3rd state, presented after reset deasserts, emerges normally one cycle later.

Source files
------------

// File: rtl/inv_sub_bytes_if.sv
// rtl/inv_sub_bytes_if.sv - state-in/state-out bundle for the InvSubBytes stage
interface inv_sub_bytes_if;
    logic         in_valid;
    logic [127:0] data_in;
    logic         out_valid;
    logic [127:0] data_out;

    modport master (
        output in_valid,
        output data_in,
        input  out_valid,
        input  data_out
    );

    modport slave (
        input  in_valid,
        input  data_in,
        output out_valid,
        output data_out
    );
endinterface

// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - AES InvSubBytes: 16 parallel inverse S-box lookups, one registered stage
module inv_sub_bytes (
    input  logic           clk,
    input  logic           rst,
    inv_sub_bytes_if.slave bus
);

    localparam logic [7:0] inv_sbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [127:0] sub_state;
    logic [127:0] state_q;
    logic         valid_q;

    // Byte 0 sits in the top 8 bits; lanes are fully independent.
    for (genvar k = 0; k < 16; k++) begin : g_lane
        assign sub_state[127-8*k -: 8] = inv_sbox[bus.data_in[127-8*k -: 8]];
    end

    // data_out only moves on an accepted state, so idle cycles hold the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 128'h0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                state_q <= sub_state;
            end
        end
    end

    assign bus.data_out  = state_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb/tb_inv_sub_bytes.sv - scoreboard bench for inv_sub_bytes against a GF(2^8) reference model
module tb_inv_sub_bytes;

    logic clk;
    logic rst;

    inv_sub_bytes_if bus ();

    inv_sub_bytes dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } item_t;

    item_t      sb[$];
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    int         n_cmp;
    int         n_fail;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from its definition (field inverse + affine map), then inverted by tabulation.
    task automatic build_model();
        logic [7:0] b;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            b = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
            end
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            fwd_tab[a] = s;
        end
        for (int a = 0; a < 256; a++) inv_tab[fwd_tab[a]] = 8'(a);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[d[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] fwd128(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = fwd_tab[d[127-8*k -: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic r);
        item_t it;
        @(negedge clk);
        bus.in_valid = v;
        bus.data_in  = d;
        rst          = r;
        if (v && !r) begin
            it.din = d;
            it.exp = model(d);
            sb.push_back(it);
        end
    endtask

    // Monitor: sample the inputs seen by each edge, then the outputs just after it.
    initial begin
        logic         started;
        logic         rst_s;
        logic         vld_s;
        logic [127:0] last;
        item_t        it;
        started = 1'b0;
        last    = 128'h0;
        forever begin
            @(posedge clk);
            rst_s = rst;
            vld_s = bus.in_valid;
            #1;
            if (rst_s) begin
                started = 1'b1;
                check("reset_out_valid", {127'h0, bus.out_valid}, 128'h0);
                check("reset_data_out", bus.data_out, 128'h0);
                last = 128'h0;
            end else if (started) begin
                check("out_valid", {127'h0, bus.out_valid}, {127'h0, vld_s});
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h, required no output", bus.data_out);
                    end else begin
                        it = sb.pop_front();
                        check("data_out", bus.data_out, it.exp);
                        check("roundtrip", fwd128(bus.data_out), it.din);
                    end
                end else begin
                    check("idle_hold", bus.data_out, last);
                end
                last = bus.data_out;
            end
        end
    end

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = '1;
        build_model();

        check("model_fips", model(128'hd42711aee0bf98f1b8b45de51e415230),
              128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check("model_63", model({16{8'h63}}), 128'h0);
        check("model_00", model(128'h0), {16{8'h52}});
        check("model_ff", model({120'h0, 8'hff}), {{15{8'h52}}, 8'h7d});
        check("model_7c", model({16{8'h7c}}), {16{8'h01}});

        drive(1'b1, '1, 1'b1);
        drive(1'b1, '1, 1'b1);
        drive(1'b0, 128'h0, 1'b0);

        drive(1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
        drive(1'b0, 128'h0, 1'b0);
        drive(1'b0, 128'h0, 1'b0);

        drive(1'b1, 128'h0, 1'b0);
        drive(1'b1, {16{8'h63}}, 1'b0);
        drive(1'b0, 128'h0, 1'b0);

        drive(1'b1, {120'h0, 8'hff}, 1'b0);
        drive(1'b0, 128'h0, 1'b0);

        for (int b = 0; b < 256; b++) drive(1'b1, {16{8'(b)}}, 1'b0);
        drive(1'b0, 128'h0, 1'b0);

        drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drive(1'b0, 128'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 49) == 0));
        end

        drive(1'b0, 128'h0, 1'b0);
        drive(1'b0, 128'h0, 1'b0);
        drive(1'b0, 128'h0, 1'b0);
        check("scoreboard_drained", 128'(sb.size()), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
